// File: rtl/spi_cmd_bridge_pkg.sv
`default_nettype none
// ============================================================================
// Module   : spi_cmd_bridge_pkg
// Brief    : Shared types and constants for the SPI command bridge.
// Revision : 1.0
// ============================================================================
package spi_cmd_bridge_pkg;

    typedef logic [7:0] byte_t;

    localparam byte_t SPI_IDLE_BYTE = 8'h00;

    typedef enum logic [0:0] {
        SPI_IDLE   = 1'b0,
        SPI_ACTIVE = 1'b1
    } spi_state_t;

endpackage
`default_nettype wire

// File: rtl/spi_cmd_bridge_sync_fifo.sv
`default_nettype none
// ============================================================================
// Module   : sync_fifo
// Brief    : Single-clock first-word-fall-through FIFO with synchronous flush.
// Revision : 1.0
// ============================================================================
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);

    localparam int             c_aw   = $clog2(DEPTH);
    localparam logic [c_aw:0]  c_full = (c_aw + 1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [c_aw-1:0]  r_wr_ptr;
    logic [c_aw-1:0]  r_rd_ptr;
    logic [c_aw:0]    r_count;
    logic             w_push;
    logic             w_pop;

    // A pop on a full FIFO frees the slot that a same-cycle push takes.
    assign w_push   = push & (~full | pop);
    assign w_pop    = pop & ~empty;
    assign full     = (r_count == c_full);
    assign empty    = (r_count == '0);
    assign pop_data = r_mem[r_rd_ptr];

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= push_data;
                r_wr_ptr        <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/spi_cmd_bridge.sv
`default_nettype none
// ============================================================================
// Module   : spi_cmd_bridge
// Brief    : Oversampled SPI mode-0 slave bridged to byte valid/ready streams.
// Revision : 1.0
// ============================================================================
module spi_cmd_bridge
    import spi_cmd_bridge_pkg::*;
#(
    parameter int    RX_DEPTH    = 16,
    parameter int    TX_DEPTH    = 16,
    parameter int    SYNC_STAGES = 2,
    parameter byte_t IDLE_BYTE   = SPI_IDLE_BYTE
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       spi_sclk,
    input  logic       spi_cs_n,
    input  logic       spi_mosi,
    output logic       spi_miso,
    output logic       cmd_in_valid,
    input  logic       cmd_in_ready,
    output logic [7:0] cmd_in_data,
    input  logic       cmd_out_valid,
    output logic       cmd_out_ready,
    input  logic [7:0] cmd_out_data,
    input  logic       cmd_reset,
    output logic       rx_overflow
);

    // Synchronizer lane {valid, sclk, cs_n, mosi}; valid marks samples taken after reset.
    localparam logic [3:0] c_sync_rst = 4'b0010;

    logic [3:0]  r_sync [SYNC_STAGES];
    logic        w_vld, w_sclk, w_cs_n, w_mosi;
    logic        r_sclk_d;
    logic        r_armed;
    spi_state_t  r_state, w_state_nxt;
    logic        w_start, w_stop, w_rise, w_fall;
    logic [2:0]  r_bit_cnt;
    logic        r_byte_seen;
    logic [6:0]  r_rx_shift;
    byte_t       r_tx_shift;
    logic        w_rx_push, w_rx_pop, w_rx_full, w_rx_empty;
    logic        w_tx_load, w_tx_push, w_tx_pop, w_tx_full, w_tx_empty;
    byte_t       w_tx_head;

    genvar g;
    generate
        for (g = 0; g < SYNC_STAGES; g++) begin : g_sync
            if (g == 0) begin : g_first
                always_ff @(posedge clk or negedge rstn) begin
                    if (!rstn) r_sync[g] <= c_sync_rst;
                    else       r_sync[g] <= {1'b1, spi_sclk, spi_cs_n, spi_mosi};
                end
            end else begin : g_next
                always_ff @(posedge clk or negedge rstn) begin
                    if (!rstn) r_sync[g] <= c_sync_rst;
                    else       r_sync[g] <= r_sync[g-1];
                end
            end
        end
    endgenerate

    assign {w_vld, w_sclk, w_cs_n, w_mosi} = r_sync[SYNC_STAGES-1];

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) r_state <= SPI_IDLE;
        else       r_state <= w_state_nxt;
    end

    // A frame may only start after cs_n has been seen high, so a frame
    // already in progress across reset is ignored until it ends.
    always_comb begin
        w_state_nxt = r_state;
        w_start     = 1'b0;
        w_stop      = 1'b0;
        case (r_state)
            SPI_IDLE: begin
                if (r_armed && w_vld && !w_cs_n) begin
                    w_state_nxt = SPI_ACTIVE;
                    w_start     = 1'b1;
                end
            end
            SPI_ACTIVE: begin
                if (w_cs_n) begin
                    w_state_nxt = SPI_IDLE;
                    w_stop      = 1'b1;
                end
            end
            default: w_state_nxt = SPI_IDLE;
        endcase
    end

    assign w_rise    = (r_state == SPI_ACTIVE) && !w_cs_n &&  w_sclk && !r_sclk_d;
    assign w_fall    = (r_state == SPI_ACTIVE) && !w_cs_n && !w_sclk &&  r_sclk_d;
    assign w_rx_push = w_rise && (r_bit_cnt == 3'd7);
    assign w_rx_pop  = cmd_in_valid & cmd_in_ready;
    assign w_tx_load = w_start || (w_fall && (r_bit_cnt == 3'd0) && r_byte_seen);
    assign w_tx_pop  = w_tx_load & ~w_tx_empty;
    assign w_tx_push = cmd_out_valid & cmd_out_ready;

    assign spi_miso      = (r_state == SPI_ACTIVE) ? r_tx_shift[7] : 1'b0;
    assign cmd_in_valid  = ~w_rx_empty;
    assign cmd_out_ready = ~w_tx_full;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_sclk_d    <= 1'b0;
            r_armed     <= 1'b0;
            r_bit_cnt   <= 3'd0;
            r_byte_seen <= 1'b0;
            r_rx_shift  <= '0;
            r_tx_shift  <= '0;
            rx_overflow <= 1'b0;
        end else begin
            r_sclk_d <= w_sclk;
            if (w_start)               r_armed <= 1'b0;
            else if (w_vld && w_cs_n)  r_armed <= 1'b1;

            if (w_start || w_stop) begin
                r_bit_cnt   <= 3'd0;
                r_byte_seen <= 1'b0;
            end else if (w_rise) begin
                r_rx_shift <= {r_rx_shift[5:0], w_mosi};
                r_bit_cnt  <= r_bit_cnt + 3'd1;
                if (r_bit_cnt == 3'd7) r_byte_seen <= 1'b1;
            end

            if (w_tx_load)   r_tx_shift <= w_tx_empty ? IDLE_BYTE : w_tx_head;
            else if (w_fall) r_tx_shift <= {r_tx_shift[6:0], 1'b0};

            if (cmd_reset)                                  rx_overflow <= 1'b0;
            else if (w_rx_push && w_rx_full && !w_rx_pop)   rx_overflow <= 1'b1;
        end
    end

    sync_fifo #(.WIDTH(8), .DEPTH(RX_DEPTH)) u_rx_fifo (
        .clk       (clk),
        .rstn      (rstn),
        .flush     (cmd_reset),
        .push      (w_rx_push),
        .push_data ({r_rx_shift, w_mosi}),
        .pop       (w_rx_pop),
        .pop_data  (cmd_in_data),
        .full      (w_rx_full),
        .empty     (w_rx_empty)
    );

    sync_fifo #(.WIDTH(8), .DEPTH(TX_DEPTH)) u_tx_fifo (
        .clk       (clk),
        .rstn      (rstn),
        .flush     (cmd_reset),
        .push      (w_tx_push),
        .push_data (cmd_out_data),
        .pop       (w_tx_pop),
        .pop_data  (w_tx_head),
        .full      (w_tx_full),
        .empty     (w_tx_empty)
    );

endmodule
`default_nettype wire

// File: tb/tb_spi_cmd_bridge.sv
`default_nettype none
// ============================================================================
// Module   : tb_spi_cmd_bridge
// Brief    : Directed self-checking bench for spi_cmd_bridge.
// Revision : 1.0
// ============================================================================
module tb_spi_cmd_bridge;

    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic       spi_sclk = 1'b0;
    logic       spi_cs_n = 1'b1;
    logic       spi_mosi = 1'b0;
    logic       spi_miso;
    logic       cmd_in_valid;
    logic       cmd_in_ready = 1'b0;
    logic [7:0] cmd_in_data;
    logic       cmd_out_valid = 1'b0;
    logic       cmd_out_ready;
    logic [7:0] cmd_out_data = 8'h00;
    logic       cmd_reset = 1'b0;
    logic       rx_overflow;

    int         n_cmp = 0;
    int         n_err = 0;
    int         rx_rd = 0;
    logic [7:0] rx_obs [$];
    logic [7:0] exp_rx [$];

    always #5 clk = ~clk;

    spi_cmd_bridge dut (
        .clk           (clk),
        .rstn          (rstn),
        .spi_sclk      (spi_sclk),
        .spi_cs_n      (spi_cs_n),
        .spi_mosi      (spi_mosi),
        .spi_miso      (spi_miso),
        .cmd_in_valid  (cmd_in_valid),
        .cmd_in_ready  (cmd_in_ready),
        .cmd_in_data   (cmd_in_data),
        .cmd_out_valid (cmd_out_valid),
        .cmd_out_ready (cmd_out_ready),
        .cmd_out_data  (cmd_out_data),
        .cmd_reset     (cmd_reset),
        .rx_overflow   (rx_overflow)
    );

    // Captures every byte the head accepts; the handshake completes on the next rising edge.
    always begin
        @(negedge clk);
        #1;
        if (cmd_in_valid && cmd_in_ready) rx_obs.push_back(cmd_in_data);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic check_rx(input string tag);
        chk({tag, "_count"}, 32'(rx_obs.size() - rx_rd), 32'(exp_rx.size()));
        while (exp_rx.size() > 0 && rx_rd < rx_obs.size()) begin
            chk({tag, "_data"}, 32'(rx_obs[rx_rd]), 32'(exp_rx.pop_front()));
            rx_rd++;
        end
        exp_rx.delete();
        rx_rd = rx_obs.size();
    endtask

    task automatic cs_low();
        @(negedge clk);
        spi_cs_n = 1'b0;
        repeat (8) @(negedge clk);
    endtask

    task automatic cs_high();
        repeat (4) @(negedge clk);
        spi_cs_n = 1'b1;
        repeat (8) @(negedge clk);
    endtask

    // Master clocks n bits of m MSB first at clk/8; s collects MISO sampled at each rise.
    task automatic spi_bits(input logic [7:0] m, input int n, output logic [7:0] s);
        s = 8'h00;
        for (int i = 7; i > 7 - n; i--) begin
            spi_mosi = m[i];
            repeat (4) @(negedge clk);
            s[i] = spi_miso;
            spi_sclk = 1'b1;
            repeat (4) @(negedge clk);
            spi_sclk = 1'b0;
        end
    endtask

    task automatic head_push(input logic [7:0] d);
        @(negedge clk);
        cmd_out_valid = 1'b1;
        cmd_out_data  = d;
        @(negedge clk);
        cmd_out_valid = 1'b0;
    endtask

    initial begin
        logic [7:0] s;
        bit         seen;

        // Reset values
        @(negedge clk);
        chk("rst_miso", 32'(spi_miso), 0);
        chk("rst_in_valid", 32'(cmd_in_valid), 0);
        chk("rst_in_data", 32'(cmd_in_data), 0);
        chk("rst_out_ready", 32'(cmd_out_ready), 1);
        chk("rst_overflow", 32'(rx_overflow), 0);
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        repeat (6) @(negedge clk);

        // Single byte receive with the TX FIFO empty
        cmd_in_ready = 1'b1;
        cs_low();
        spi_bits(8'hA5, 8, s);
        exp_rx.push_back(8'hA5);
        chk("t1_miso", 32'(s), 32'h00);
        cs_high();
        check_rx("t1_rx");

        // Response byte then idle byte
        head_push(8'h3C);
        cs_low();
        spi_bits(8'h5A, 8, s);
        exp_rx.push_back(8'h5A);
        chk("t2_miso0", 32'(s), 32'h3C);
        spi_bits(8'hC3, 8, s);
        exp_rx.push_back(8'hC3);
        chk("t2_miso1", 32'(s), 32'h00);
        cs_high();
        check_rx("t2_rx");

        // RX overflow: 17 bytes with the head stalled
        cmd_in_ready = 1'b0;
        cs_low();
        for (int i = 0; i < 17; i++) begin
            spi_bits(8'(8'h10 + i), 8, s);
            if (i < 16) exp_rx.push_back(8'(8'h10 + i));
        end
        cs_high();
        chk("t3_overflow", 32'(rx_overflow), 1);
        chk("t3_valid", 32'(cmd_in_valid), 1);
        cmd_in_ready = 1'b1;
        repeat (24) @(negedge clk);
        cmd_in_ready = 1'b0;
        check_rx("t3_rx");
        chk("t3_sticky", 32'(rx_overflow), 1);

        // cmd_reset flushes a pending byte and clears the overflow flag
        cs_low();
        spi_bits(8'h99, 8, s);
        cs_high();
        chk("t3b_valid_pre", 32'(cmd_in_valid), 1);
        @(negedge clk);
        cmd_reset = 1'b1;
        @(negedge clk);
        cmd_reset = 1'b0;
        chk("t3b_valid_post", 32'(cmd_in_valid), 0);
        chk("t3b_overflow", 32'(rx_overflow), 0);

        // Aborted partial byte is discarded
        cmd_in_ready = 1'b1;
        cs_low();
        spi_bits(8'hFF, 5, s);
        cs_high();
        cs_low();
        spi_bits(8'h12, 8, s);
        exp_rx.push_back(8'h12);
        cs_high();
        check_rx("t4_rx");

        // TX FIFO full, then a frame-start pop lets one more head byte in
        for (int i = 0; i < 16; i++) head_push(8'(8'hC0 + i));
        chk("t5_ready_full", 32'(cmd_out_ready), 0);
        cmd_out_valid = 1'b1;
        cmd_out_data  = 8'hEE;
        @(negedge clk);
        spi_cs_n = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 20 && !seen; k++) begin
            @(negedge clk);
            if (cmd_out_ready) seen = 1'b1;
        end
        chk("t5_ready_freed", 32'(seen), 1);
        @(negedge clk);
        cmd_out_valid = 1'b0;
        chk("t5_ready_refull", 32'(cmd_out_ready), 0);
        repeat (6) @(negedge clk);
        for (int i = 0; i < 17; i++) begin
            spi_bits(8'h00, 8, s);
            exp_rx.push_back(8'h00);
            chk("t5_miso", 32'(s), (i < 16) ? 32'(8'hC0 + i) : 32'hEE);
        end
        cs_high();
        check_rx("t5_rx");

        // Asynchronous reset mid-byte, then recovery
        cmd_in_ready = 1'b0;
        head_push(8'h77);
        head_push(8'hFF);
        cs_low();
        spi_bits(8'h55, 8, s);
        chk("t6_miso", 32'(s), 32'h77);
        spi_bits(8'h00, 3, s);
        chk("t6_pre_valid", 32'(cmd_in_valid), 1);
        #2;
        rstn = 1'b0;
        #1;
        chk("t6_miso_rst", 32'(spi_miso), 0);
        chk("t6_valid_rst", 32'(cmd_in_valid), 0);
        chk("t6_data_rst", 32'(cmd_in_data), 0);
        chk("t6_ready_rst", 32'(cmd_out_ready), 1);
        chk("t6_ovf_rst", 32'(rx_overflow), 0);
        repeat (3) @(negedge clk);
        rstn = 1'b1;
        cmd_in_ready = 1'b1;
        spi_bits(8'hF0, 8, s);
        cs_high();
        cs_low();
        spi_bits(8'h81, 8, s);
        exp_rx.push_back(8'h81);
        cs_high();
        check_rx("t6_rx");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
